code_seq_detect: RTL and testbench
==================================

Name: code_seq_detect

Overview:
- Downstream consumer of the 4-bit code-mapping stage: samples its 4-bit code output each cycle that in_valid is high.
- Detects the ordered three-code sequence CODE0 -> CODE1 -> CODE2, possibly split by idle cycles.
- Emits a one-cycle match pulse and keeps a saturating hit count plus the last accepted code for the top level and bench.

Parameters:
CODE0, 4'b1110, first code of the sequence
CODE1, 4'b1101, second code of the sequence
CODE2, 4'b0111, third code of the sequence
CNT_W, 8, width of hit counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  in_code is valid this cycle
in_code  input  4  code from the upstream mapping stage
clr  input  1  synchronous clear of state, counter and match
match  output  1  registered one-cycle pulse on sequence completion
state_o  output  2  current FSM state encoding
hit_cnt  output  CNT_W  number of completed sequences
last_code  output  4  last code accepted with in_valid

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All outputs and registers reset immediately, independent of clk: state IDLE, match 0, hit_cnt 0, last_code 4'b0000.
- Reset mid-sequence discards partial progress. The first edge after rst deasserts behaves as from IDLE.
- FSM encoding: IDLE=2'd0, S1=2'd1 (CODE0 seen), S2=2'd2 (CODE0,CODE1 seen). 2'd3 is unused and recovers to IDLE on the next edge.
- State advances only on edges where in_valid=1. With in_valid=0, state, last_code and hit_cnt hold and match is 0.
- IDLE: CODE0 -> S1; any other code -> IDLE.
- S1: CODE1 -> S2; CODE0 -> S1 (restart); other -> IDLE.
- S2: CODE2 -> IDLE, match=1 next cycle, hit_cnt+1; CODE0 -> S1; other -> IDLE.
- Overlap rule: a mismatching code equal to CODE0 always lands in S1, never IDLE.
- match: registered, high exactly for the cycle after the edge that accepted CODE2. Back-to-back sequences need at least 3 accepted codes, so match is never high on two consecutive cycles.
- hit_cnt: unsigned, increments by 1 per match and saturates at all-ones (2^CNT_W-1); it does not wrap.
- last_code: loads in_code on every in_valid edge, including edges where clr=1.
- clr: synchronous. On that edge: state IDLE, hit_cnt 0, match 0. clr has priority over the FSM transition and counter increment in the same cycle, so a CODE2 arriving with clr=1 is not counted.
- Latency: in_code to state_o is 1 cycle. Sampling edge to match is 1 cycle.
- Combinational outputs: none; all outputs are registered.

Optional Feature:
- Macro CODE_SEQ_DETECT_CNT_WRAP_EN defined: hit_cnt wraps from 2^CNT_W-1 to 0 on the next match. Match still pulses normally.
- Macro not defined (default): hit_cnt saturates as above. Port list is identical in both builds.

Test Plan:
- Reset during S2 (rst=1 mid-cycle) -> outputs 0 immediately, without a clock edge. Next 1101,0111 -> no match.
- in_valid stream 1110,1101,0111 -> state_o 1,2,0. match=1 one cycle after the 0111 edge. hit_cnt=1. last_code=0111.
- Stream 1110,0011,1101,0111 -> state_o 1,0,0,0, no match, hit_cnt=0. Stream 1110,1110,1101,0111 -> match once (restart rule).
- Stream 1110, idle 5 cycles with in_valid=0 and in_code toggling, 1101, 0111 -> match=1. last_code is unchanged during idle.
- CNT_W=2, 5 full sequences -> hit_cnt 1,2,3,3,3 by default. With CODE_SEQ_DETECT_CNT_WRAP_EN: 1,2,3,0,1.
- Stream 1110,1101 then 0111 with clr=1 on the same edge -> match=0, hit_cnt=0, state_o=0, last_code=0111.

Source files
------------

// File: rtl/code_seq_detect.sv
// code_seq_detect: finds the ordered code sequence CODE0 -> CODE1 -> CODE2 in a
// valid-qualified 4-bit code stream; idle cycles may separate the codes.
// Build option: CODE_SEQ_DETECT_CNT_WRAP_EN makes hit_cnt wrap instead of saturate.
module code_seq_detect #(
    parameter logic [3:0] CODE0 = 4'b1110,
    parameter logic [3:0] CODE1 = 4'b1101,
    parameter logic [3:0] CODE2 = 4'b0111,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_code,
    input  logic             clr,
    output logic             match,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [3:0]       last_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        S1    = 2'd1,
        S2    = 2'd2,
        S_BAD = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   match_next;
    logic   hit;

    // State register; reset and clear both return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; clr overrides any transition, and a code equal to
    // CODE0 always restarts the sequence in S1.
    always_comb begin
        state_next = state;
        match_next = 1'b0;
        hit        = 1'b0;
        if (clr) begin
            state_next = IDLE;
        end else if (state == S_BAD) begin
            state_next = IDLE;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    state_next = (in_code == CODE0) ? S1 : IDLE;
                end
                S1: begin
                    if (in_code == CODE1)      state_next = S2;
                    else if (in_code == CODE0) state_next = S1;
                    else                       state_next = IDLE;
                end
                S2: begin
                    if (in_code == CODE2) begin
                        state_next = IDLE;
                        match_next = 1'b1;
                        hit        = 1'b1;
                    end else if (in_code == CODE0) begin
                        state_next = S1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Registered one-cycle match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match <= 1'b0;
        end else begin
            match <= match_next;
        end
    end

    // Hit counter: cleared by clr, otherwise counts completed sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (clr) begin
            hit_cnt <= '0;
        end else if (hit) begin
`ifdef CODE_SEQ_DETECT_CNT_WRAP_EN
            hit_cnt <= hit_cnt + CNT_W'(1);
`else
            if (hit_cnt != {CNT_W{1'b1}}) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
`endif
        end
    end

    // Last accepted code; loads on every valid edge, even while clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_code <= 4'b0000;
        end else if (in_valid) begin
            last_code <= in_code;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_code_seq_detect.sv
// Randomized and directed checks of code_seq_detect against a window-based
// reference model, on a default-width instance and a 2-bit-counter instance.
module tb_code_seq_detect;

    localparam logic [3:0] C0 = 4'b1110;
    localparam logic [3:0] C1 = 4'b1101;
    localparam logic [3:0] C2 = 4'b0111;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_code;
    logic       clr;

    logic       match8, match2;
    logic [1:0] state8, state2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [3:0] last8, last2;

    int errors = 0;
    int checks = 0;

    // Reference model: last three accepted codes since reset/clear
    // (5'h10 marks an empty slot), plus expected counters.
    logic [4:0] win [3];
    int         m_cnt8, m_cnt2;
    logic       m_match;
    logic [3:0] m_last;

    always #5 clk = ~clk;

    code_seq_detect #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr(clr),
        .match(match8), .state_o(state8), .hit_cnt(cnt8), .last_code(last8)
    );

    code_seq_detect #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr(clr),
        .match(match2), .state_o(state2), .hit_cnt(cnt2), .last_code(last2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) win[i] = 5'h10;
        m_cnt8  = 0;
        m_cnt2  = 0;
        m_match = 1'b0;
        m_last  = 4'b0000;
    endtask

    function automatic logic [1:0] m_state();
        if (win[0] == {1'b0, C0})                             return 2'd1;
        if (win[1] == {1'b0, C0} && win[0] == {1'b0, C1})     return 2'd2;
        return 2'd0;
    endfunction

    function automatic int bump(input int cnt, input int modulus);
`ifdef CODE_SEQ_DETECT_CNT_WRAP_EN
        return (cnt + 1) % modulus;
`else
        return (cnt < modulus - 1) ? cnt + 1 : cnt;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_state8"}, 32'(state8), 32'(m_state()));
        chk({tag, "_state2"}, 32'(state2), 32'(m_state()));
        chk({tag, "_match8"}, 32'(match8), 32'(m_match));
        chk({tag, "_match2"}, 32'(match2), 32'(m_match));
        chk({tag, "_cnt8"},   32'(cnt8),   32'(m_cnt8));
        chk({tag, "_cnt2"},   32'(cnt2),   32'(m_cnt2));
        chk({tag, "_last8"},  32'(last8),  32'(m_last));
        chk({tag, "_last2"},  32'(last2),  32'(m_last));
    endtask

    // One clock: drive at negedge, update model at posedge, check 1 time unit later.
    task automatic step(input logic v, input logic [3:0] code, input logic c, input string tag);
        @(negedge clk);
        in_valid = v;
        in_code  = code;
        clr      = c;
        @(posedge clk);
        m_match = 1'b0;
        if (c) begin
            for (int i = 0; i < 3; i++) win[i] = 5'h10;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (v) begin
            win[2] = win[1];
            win[1] = win[0];
            win[0] = {1'b0, code};
            if (win[2] == {1'b0, C0} && win[1] == {1'b0, C1} && win[0] == {1'b0, C2}) begin
                m_match = 1'b1;
                m_cnt8  = bump(m_cnt8, 256);
                m_cnt2  = bump(m_cnt2, 4);
                for (int i = 0; i < 3; i++) win[i] = 5'h10;
            end
        end
        if (v) m_last = code;
        #1;
        check_all(tag);
    endtask

    task automatic seq_full(input string tag);
        step(1'b1, C0, 1'b0, tag);
        step(1'b1, C1, 1'b0, tag);
        step(1'b1, C2, 1'b0, tag);
    endtask

    initial begin
        int pick;
        logic [3:0] rc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_code  = 4'h0;
        clr      = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic sequence with state progression 1,2,0 and a match pulse.
        seq_full("basic");
        chk("basic_cnt_const", 32'(cnt8), 32'd1);
        step(1'b0, 4'h0, 1'b0, "basic_after");

        // Broken sequence, then restart rule.
        step(1'b1, C0, 1'b0, "broken");
        step(1'b1, 4'b0011, 1'b0, "broken");
        step(1'b1, C1, 1'b0, "broken");
        step(1'b1, C2, 1'b0, "broken");
        step(1'b1, C0, 1'b0, "restart");
        step(1'b1, C0, 1'b0, "restart");
        step(1'b1, C1, 1'b0, "restart");
        step(1'b1, C2, 1'b0, "restart");
        chk("restart_match_const", 32'(match8), 32'd1);

        // Idle gaps with in_code toggling while in_valid is low.
        step(1'b1, C0, 1'b0, "idle");
        for (int i = 0; i < 5; i++) step(1'b0, 4'($urandom), 1'b0, "idle_gap");
        step(1'b1, C1, 1'b0, "idle");
        step(1'b1, C2, 1'b0, "idle");

        // Clear arriving together with the final code.
        step(1'b1, C0, 1'b0, "clr");
        step(1'b1, C1, 1'b0, "clr");
        step(1'b1, C2, 1'b1, "clr");
        chk("clr_last_const", 32'(last8), 32'(C2));

        // Counter boundary: five sequences on the 2-bit instance.
        for (int i = 0; i < 5; i++) seq_full("sat");
`ifdef CODE_SEQ_DETECT_CNT_WRAP_EN
        chk("sat_cnt2_const", 32'(cnt2), 32'd1);
`else
        chk("sat_cnt2_const", 32'(cnt2), 32'd3);
`endif

        // Asynchronous reset while in S2, observed without a clock edge.
        step(1'b1, C0, 1'b0, "areset_pre");
        step(1'b1, C1, 1'b0, "areset_pre");
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("areset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, C1, 1'b0, "areset_post");
        step(1'b1, C2, 1'b0, "areset_post");
        chk("areset_nomatch_const", 32'(match8), 32'd0);

        // Randomized stream biased toward the sequence codes.
        for (int i = 0; i < 600; i++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2: rc = C0;
                3, 4:    rc = C1;
                5, 6:    rc = C2;
                default: rc = 4'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, rc, $urandom_range(0, 40) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
